// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit pipelined processor datapath.
package proc_pkg;

   localparam int unsigned W    = 16;
   localparam int unsigned RD_W = 3;

   // Bit positions inside the {C,Z,N} condition-code vector.
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/ex_mem_stage_ccr_unit.sv
// Architectural condition-code register with its interrupt shadow copy.
module ccr_unit
   import proc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       commit,
   input  logic       carry,
   input  logic       zero,
   input  logic       neg,
   input  logic [2:0] flag_en,
   input  logic       setc,
   input  logic       clrc,
   input  logic       save,
   input  logic       restore,
   output logic [2:0] ccr
);

   logic [2:0] ccr_q;
   logic [2:0] shadow_q;
   logic [2:0] ccr_next;

   // Next CCR value: per-flag commit, C set/clear priority, restore overrides all.
   always_comb begin
      ccr_next = ccr_q;
      if (commit) begin
         if (flag_en[FLAG_Z]) ccr_next[FLAG_Z] = zero;
         if (flag_en[FLAG_N]) ccr_next[FLAG_N] = neg;
         if (setc)                 ccr_next[FLAG_C] = 1'b1;
         else if (clrc)            ccr_next[FLAG_C] = 1'b0;
         else if (flag_en[FLAG_C]) ccr_next[FLAG_C] = carry;
      end
      if (restore) ccr_next = shadow_q;
   end

   // CCR and shadow registers; save captures the pre-update CCR unless a restore is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         ccr_q    <= '0;
         shadow_q <= '0;
      end else begin
         ccr_q <= ccr_next;
         if (save && !restore) shadow_q <= ccr_q;
      end
   end

   assign ccr = ccr_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, CCR ownership and EX/MEM forwarding path.
module ex_mem_stage
   import proc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic [W-1:0]    ex_result,
   input  logic            ex_carry,
   input  logic            ex_zero,
   input  logic            ex_neg,
   input  logic [2:0]      ex_flag_en,
   input  logic            ex_setc,
   input  logic            ex_clrc,
   input  logic [RD_W-1:0] ex_rd,
   input  logic            ex_reg_we,
   input  logic            ex_mem_rd,
   input  logic            ex_mem_wr,
   input  logic [W-1:0]    ex_store_data,
   input  logic            stall,
   input  logic            flush,
   input  logic            ccr_save,
   input  logic            ccr_restore,
   output logic            mem_valid,
   output logic [W-1:0]    mem_result,
   output logic [RD_W-1:0] mem_rd,
   output logic            mem_reg_we,
   output logic            mem_mem_rd,
   output logic            mem_mem_wr,
   output logic [W-1:0]    mem_store_data,
   output logic [2:0]      ccr,
   output logic            fwd_en,
   output logic [RD_W-1:0] fwd_rd,
   output logic [W-1:0]    fwd_data
);

   logic commit;

   assign commit = ex_valid & ~stall & ~flush;

   ccr_unit u_ccr (
      .clk     (clk),
      .reset   (reset),
      .commit  (commit),
      .carry   (ex_carry),
      .zero    (ex_zero),
      .neg     (ex_neg),
      .flag_en (ex_flag_en),
      .setc    (ex_setc),
      .clrc    (ex_clrc),
      .save    (ccr_save),
      .restore (ccr_restore),
      .ccr     (ccr)
   );

   // Pipeline register: flush clears controls only, stall holds, otherwise load (bubble when not valid).
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid      <= 1'b0;
         mem_result     <= '0;
         mem_rd         <= '0;
         mem_reg_we     <= 1'b0;
         mem_mem_rd     <= 1'b0;
         mem_mem_wr     <= 1'b0;
         mem_store_data <= '0;
      end else if (flush) begin
         mem_valid  <= 1'b0;
         mem_reg_we <= 1'b0;
         mem_mem_rd <= 1'b0;
         mem_mem_wr <= 1'b0;
      end else if (!stall) begin
         mem_valid      <= ex_valid;
         mem_result     <= ex_result;
         mem_rd         <= ex_rd;
         mem_reg_we     <= ex_valid & ex_reg_we;
         mem_mem_rd     <= ex_valid & ex_mem_rd;
         mem_mem_wr     <= ex_valid & ex_mem_wr;
         mem_store_data <= ex_store_data;
      end
   end

   assign fwd_en   = mem_valid & mem_reg_we;
   assign fwd_rd   = mem_rd;
   assign fwd_data = mem_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;
   import proc_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            ex_valid;
   logic [W-1:0]    ex_result;
   logic            ex_carry, ex_zero, ex_neg;
   logic [2:0]      ex_flag_en;
   logic            ex_setc, ex_clrc;
   logic [RD_W-1:0] ex_rd;
   logic            ex_reg_we, ex_mem_rd, ex_mem_wr;
   logic [W-1:0]    ex_store_data;
   logic            stall, flush, ccr_save, ccr_restore;
   logic            mem_valid;
   logic [W-1:0]    mem_result;
   logic [RD_W-1:0] mem_rd;
   logic            mem_reg_we, mem_mem_rd, mem_mem_wr;
   logic [W-1:0]    mem_store_data;
   logic [2:0]      ccr;
   logic            fwd_en;
   logic [RD_W-1:0] fwd_rd;
   logic [W-1:0]    fwd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_carry(ex_carry), .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_flag_en(ex_flag_en),
      .ex_setc(ex_setc), .ex_clrc(ex_clrc), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data),
      .stall(stall), .flush(flush), .ccr_save(ccr_save), .ccr_restore(ccr_restore),
      .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
      .mem_reg_we(mem_reg_we), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
      .mem_store_data(mem_store_data), .ccr(ccr), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data)
   );

   task automatic idle();
      reset = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_carry = 1'b0; ex_zero = 1'b0;
      ex_neg = 1'b0; ex_flag_en = '0; ex_setc = 1'b0; ex_clrc = 1'b0; ex_rd = '0;
      ex_reg_we = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_store_data = '0;
      stall = 1'b0; flush = 1'b0; ccr_save = 1'b0; ccr_restore = 1'b0;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single flag-commit instruction: set flags {c,z,n} with all enables on.
   task automatic commit_flags(input logic [2:0] f);
      idle();
      ex_valid = 1'b1; ex_flag_en = 3'b111;
      ex_carry = f[2]; ex_zero = f[1]; ex_neg = f[0];
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1; stall = 1'b1; flush = 1'b1; ccr_save = 1'b1; ccr_restore = 1'b1;
      ex_valid = 1'b1; ex_result = 16'hFFFF; ex_reg_we = 1'b1; ex_setc = 1'b1;
      tick();
      tick();
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
      checks++; if (mem_result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", mem_result); end
      checks++; if (ccr !== 3'b000) begin failures++; $display("FAIL reset_ccr got=%b exp=000", ccr); end
      checks++; if (fwd_en !== 1'b0) begin failures++; $display("FAIL reset_fwd_en got=%b exp=0", fwd_en); end
      idle();
   endtask

   task automatic test_load_forward();
      idle();
      ex_valid = 1'b1; ex_result = 16'h0023; ex_rd = 3'd5; ex_reg_we = 1'b1;
      ex_mem_wr = 1'b1; ex_store_data = 16'hBEEF;
      tick();
      checks++; if (mem_result !== 16'h0023) begin failures++; $display("FAIL load_result got=%h exp=0023", mem_result); end
      checks++; if (fwd_en !== 1'b1) begin failures++; $display("FAIL load_fwd_en got=%b exp=1", fwd_en); end
      checks++; if (fwd_rd !== 3'd5) begin failures++; $display("FAIL load_fwd_rd got=%0d exp=5", fwd_rd); end
      checks++; if (fwd_data !== 16'h0023) begin failures++; $display("FAIL load_fwd_data got=%h exp=0023", fwd_data); end
      checks++; if (mem_store_data !== 16'hBEEF || mem_mem_wr !== 1'b1 || mem_mem_rd !== 1'b0)
         begin failures++; $display("FAIL load_mem_ctl got=%h/%b/%b exp=beef/1/0", mem_store_data, mem_mem_wr, mem_mem_rd); end
      // Bubble: controls present on the inputs must not leak through.
      idle();
      ex_reg_we = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; ex_result = 16'h0077;
      ex_flag_en = 3'b111; ex_carry = 1'b1; ex_zero = 1'b1; ex_neg = 1'b1;
      tick();
      checks++; if ({mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, fwd_en} !== 5'b00000)
         begin failures++; $display("FAIL bubble_ctl got=%b exp=00000", {mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, fwd_en}); end
      checks++; if (ccr !== 3'b000) begin failures++; $display("FAIL bubble_ccr got=%b exp=000", ccr); end
      idle();
   endtask

   task automatic test_flag_mask();
      idle();
      ex_valid = 1'b1; ex_carry = 1'b1; ex_zero = 1'b1; ex_neg = 1'b1; ex_flag_en = 3'b011;
      tick();
      checks++; if (ccr !== 3'b011) begin failures++; $display("FAIL mask_zn got=%b exp=011", ccr); end
      idle();
      ex_valid = 1'b1; ex_setc = 1'b1;
      tick();
      checks++; if (ccr !== 3'b111) begin failures++; $display("FAIL mask_setc got=%b exp=111", ccr); end
      idle();
      ex_valid = 1'b1; ex_clrc = 1'b1; ex_flag_en = 3'b100; ex_carry = 1'b1;
      tick();
      checks++; if (ccr !== 3'b011) begin failures++; $display("FAIL mask_clrc_over_en got=%b exp=011", ccr); end
      idle();
      ex_valid = 1'b1; ex_setc = 1'b1; ex_clrc = 1'b1;
      tick();
      checks++; if (ccr !== 3'b111) begin failures++; $display("FAIL mask_setc_over_clrc got=%b exp=111", ccr); end
      idle();
      ex_valid = 1'b1; ex_flag_en = 3'b100; ex_carry = 1'b0; ex_zero = 1'b0; ex_neg = 1'b0;
      tick();
      checks++; if (ccr !== 3'b011) begin failures++; $display("FAIL mask_c_only got=%b exp=011", ccr); end
      idle();
   endtask

   task automatic test_stall_flush();
      commit_flags(3'b000);
      ex_result = 16'h00AA; ex_rd = 3'd2; ex_reg_we = 1'b1;
      tick();
      checks++; if (mem_result !== 16'h00AA || ccr !== 3'b000)
         begin failures++; $display("FAIL stall_pre got=%h/%b exp=00aa/000", mem_result, ccr); end
      commit_flags(3'b111);
      ex_result = 16'h0055; ex_rd = 3'd6; ex_reg_we = 1'b1; ex_setc = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_result !== 16'h00AA || mem_rd !== 3'd2 || fwd_en !== 1'b1 || ccr !== 3'b000)
            begin failures++; $display("FAIL stall_hold_%0d got=%h/%0d/%b/%b exp=00aa/2/1/000", i, mem_result, mem_rd, fwd_en, ccr); end
      end
      flush = 1'b1;
      tick();
      checks++; if (mem_valid !== 1'b0 || fwd_en !== 1'b0)
         begin failures++; $display("FAIL flush_stall got=%b/%b exp=0/0", mem_valid, fwd_en); end
      checks++; if (mem_result !== 16'h00AA || ccr !== 3'b000)
         begin failures++; $display("FAIL flush_keep got=%h/%b exp=00aa/000", mem_result, ccr); end
      stall = 1'b0;
      tick();
      checks++; if (mem_valid !== 1'b0 || ccr !== 3'b000)
         begin failures++; $display("FAIL flush_only got=%b/%b exp=0/000", mem_valid, ccr); end
      idle();
   endtask

   task automatic test_save_restore();
      commit_flags(3'b101);
      tick();
      checks++; if (ccr !== 3'b101) begin failures++; $display("FAIL sr_setup got=%b exp=101", ccr); end
      commit_flags(3'b010); ccr_save = 1'b1;
      tick();
      checks++; if (ccr !== 3'b010) begin failures++; $display("FAIL sr_save_commit got=%b exp=010", ccr); end
      commit_flags(3'b111); ccr_restore = 1'b1;
      tick();
      checks++; if (ccr !== 3'b101) begin failures++; $display("FAIL sr_restore_over_commit got=%b exp=101", ccr); end
      commit_flags(3'b000);
      tick();
      idle(); ccr_save = 1'b1; ccr_restore = 1'b1;
      tick();
      checks++; if (ccr !== 3'b101) begin failures++; $display("FAIL sr_both_restore got=%b exp=101", ccr); end
      commit_flags(3'b011);
      tick();
      idle(); ccr_restore = 1'b1;
      tick();
      checks++; if (ccr !== 3'b101) begin failures++; $display("FAIL sr_both_shadow_kept got=%b exp=101", ccr); end
      // Save under stall, restore under flush.
      commit_flags(3'b110);
      tick();
      idle(); stall = 1'b1; ccr_save = 1'b1;
      tick();
      commit_flags(3'b001);
      tick();
      idle(); flush = 1'b1; ccr_restore = 1'b1;
      tick();
      checks++; if (ccr !== 3'b110) begin failures++; $display("FAIL sr_stall_flush got=%b exp=110", ccr); end
      idle();
   endtask

   task automatic test_reset_mid();
      commit_flags(3'b111);
      ex_result = 16'h1234; ex_rd = 3'd3; ex_reg_we = 1'b1; ex_mem_wr = 1'b1; ex_store_data = 16'h5678;
      tick();
      idle(); ccr_save = 1'b1; stall = 1'b1;
      tick();
      checks++; if (mem_result !== 16'h1234 || ccr !== 3'b111)
         begin failures++; $display("FAIL rst_pre got=%h/%b exp=1234/111", mem_result, ccr); end
      idle(); stall = 1'b1; reset = 1'b1;
      tick();
      checks++; if ({mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr} !== 4'b0000 || mem_result !== '0 ||
                    mem_rd !== '0 || mem_store_data !== '0 || fwd_en !== 1'b0)
         begin failures++; $display("FAIL rst_mem got=%b/%h/%0d/%h exp=0000/0000/0/0000",
                  {mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr}, mem_result, mem_rd, mem_store_data); end
      checks++; if (ccr !== 3'b000) begin failures++; $display("FAIL rst_ccr got=%b exp=000", ccr); end
      commit_flags(3'b011);
      ex_setc = 1'b1; ex_result = 16'h0BEE; ex_rd = 3'd2; ex_reg_we = 1'b1;
      tick();
      checks++; if (mem_result !== 16'h0BEE || fwd_en !== 1'b1 || fwd_rd !== 3'd2 || ccr !== 3'b111)
         begin failures++; $display("FAIL rst_first_load got=%h/%b/%0d/%b exp=0bee/1/2/111", mem_result, fwd_en, fwd_rd, ccr); end
      idle(); ccr_restore = 1'b1;
      tick();
      checks++; if (ccr !== 3'b000) begin failures++; $display("FAIL rst_shadow got=%b exp=000", ccr); end
      idle();
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_load_forward();
      test_flag_mask();
      test_stall_flush();
      test_save_restore();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory boundary of the 16-bit pipelined processor. Captures the ALU outputs (result, carry, zero, neg) and the control fields travelling with them into the EX/MEM pipeline register. Owns the architectural condition-code register (CCR), including its interrupt shadow copy. Drives the EX/MEM forwarding path back to the ALU operand muxes.

## Interface
- `W`, 16, datapath width (ALU result, store data)
- `RD_W`, 3, destination register index width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  EX holds a real instruction this cycle
- `ex_result`  in  W  ALU result
- `ex_carry`, `ex_zero`, `ex_neg`  in  1 each  ALU flag outputs
- `ex_flag_en`  in  3  per-flag update enable, bit order {C,Z,N}
- `ex_setc`, `ex_clrc`  in  1 each  force C to 1 / 0
- `ex_rd`  in  RD_W  destination register
- `ex_reg_we`, `ex_mem_rd`, `ex_mem_wr`  in  1 each  writeback and memory controls
- `ex_store_data`  in  W  store operand
- `stall`  in  1  hold EX/MEM contents and CCR
- `flush`  in  1  insert a bubble into EX/MEM
- `ccr_save`  in  1  interrupt entry: copy CCR to shadow
- `ccr_restore`  in  1  RTI: load CCR from shadow
- `mem_valid`, `mem_result`, `mem_rd`, `mem_reg_we`, `mem_mem_rd`, `mem_mem_wr`, `mem_store_data`  out  1/W/RD_W/1/1/1/W  registered EX/MEM fields
- `ccr`  out  3  architectural flags {C,Z,N}, consumed by the branch unit
- `fwd_en`  out  1  equals `mem_valid & mem_reg_we`
- `fwd_rd`  out  RD_W  equals `mem_rd`
- `fwd_data`  out  W  equals `mem_result`

## Operation
- Pipeline register action per cycle, priority flush > stall > load.
  - **flush**: `mem_valid`, `mem_reg_we`, `mem_mem_rd` and `mem_mem_wr` go to 0; data fields are don't-care and keep their values.
  - **stall**: all `mem_*` fields hold.
  - **load**: all `mem_*` fields take the `ex_*` values. `ex_valid`=0 loads a bubble with all controls 0.
- CCR commit condition: `ex_valid & ~stall & ~flush`.
- On commit, per-flag update:
  - Z takes `ex_zero` when `ex_flag_en[1]`, else holds.
  - N takes `ex_neg` when `ex_flag_en[0]`, else holds.
  - C priority: `ex_setc` (→1) > `ex_clrc` (→0) > `ex_flag_en[2]` (→`ex_carry`) > hold.
- `ccr_restore` overrides any commit in the same cycle: CCR takes the shadow value.
- `ccr_save` latches the CCR value from before this cycle's update.
- `ccr_save` and `ccr_restore` in the same cycle: restore happens and the shadow is unchanged.
- `ccr_save` and `ccr_restore` act regardless of `stall` and `flush`.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Latency 1 cycle, `ex_*` to `mem_*`. A flag update becomes visible on `ccr` the cycle after commit.
- All outputs are registered or a pure function of registers; no combinational path from inputs to outputs.
- Reset: all `mem_*` = 0, `ccr` = 3'b000, shadow = 3'b000, `fwd_en` = 0.
- Reset wins over flush, stall, save and restore.
- Reset asserted mid-stall clears the held instruction; the first post-reset load is accepted in the cycle reset deasserts.
- Back-to-back stalls may be of any length with no loss of data.
- A flush in the same cycle as a stall drops the held instruction.

## Structure
- Shared package `proc_pkg`:
  - `W`, `RD_W`
  - flag index constants `FLAG_C`=2, `FLAG_Z`=1, `FLAG_N`=0
- One sub-module: `ccr_unit`. It holds the CCR and shadow registers with the commit, set/clear and save/restore priority logic.
- `ex_mem_stage` instantiates `ccr_unit` and contains the pipeline register and forwarding outputs.

## Test plan
- **Load and forward:** `ex_valid`=1, `ex_result`=16'h0023, `ex_rd`=5, `ex_reg_we`=1 → next cycle `mem_result`=16'h0023, `fwd_en`=1, `fwd_rd`=5.
- **Flag masking:** CCR=000, then `ex_carry`=1, `ex_zero`=1, `ex_neg`=1, `ex_flag_en`=3'b011 → `ccr`=3'b011. Then `ex_setc`=1 with `ex_flag_en`=0 → `ccr`=3'b111.
- **Stall and flush:** load result 16'h00AA, then hold `stall` for 3 cycles while `ex_result`=16'h0055 → `mem_result` stays 16'h00AA and `ccr` is unchanged. Then `flush`=1 together with `stall`=1 → `mem_valid`=0 and `fwd_en`=0.
- **Save/restore:**
  - `ccr`=3'b101, assert `ccr_save` in the same cycle as a commit that sets `ccr` to 3'b010 → shadow = 101.
  - Later `ccr_restore` together with a commit → `ccr`=3'b101.
  - `ccr_save` and `ccr_restore` together → restore happens and the shadow is unchanged.
- **Reset mid-operation:** with a valid stalled instruction and `ccr`=3'b111, pulse `reset` for 1 cycle → all `mem_*`=0, `ccr`=3'b000, shadow=000; the next load is accepted normally.
